// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: issues word requests over req/ack, buffers returned words with their PC in a FIFO.
// Optional FETCH_STATS_EN adds a saturating stall_cycles_o counter.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_data_o,
    output logic [31:0] inst_pc_o,
`ifdef FETCH_STATS_EN
    output logic [31:0] stall_cycles_o,
`endif
    output logic [1:0]  state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       addr_q, addr_d;
    logic              req_q, req_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       mem_pc_q   [DEPTH];
    logic [31:0]       mem_data_q [DEPTH];

    logic              push;
    logic              pop;
    logic [CW-1:0]     count_after;
    logic              space_ok;

    // A redirect kills any response arriving in the same cycle.
    assign push        = (state_q == S_WAIT) && imem_ack_i && !redirect_valid_i;
    assign pop         = inst_valid_o && inst_ready_i;
    assign count_after = count_q + CW'(push) - CW'(pop);
    assign space_ok    = count_after < CW'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_after;

        if (redirect_valid_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            case (state_q)
                S_WAIT: begin
                    if (imem_ack_i) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (space_ok) begin
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (space_ok) begin
                            addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
                mem_data_q[wr_ptr_q] <= imem_rdata_i;
            end
        end
    end

    // Head is read straight from registered storage; imem_rdata never reaches decode combinationally.
    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = (count_q != '0);
    assign inst_data_o  = mem_data_q[rd_ptr_q];
    assign inst_pc_o    = mem_pc_q[rd_ptr_q];
    assign state_o      = state_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (!inst_valid_o && (state_q != S_DROP) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: cycle table, reset/stats sequences, then random traffic against a stream model.
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [1:0]  state;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ack_i       (imem_ack),
        .imem_rdata_i     (imem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_data_o      (inst_data),
        .inst_pc_o        (inst_pc),
`ifdef FETCH_STATS_EN
        .stall_cycles_o   (stall_cycles),
`endif
        .state_o          (state)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic ack, input logic ready, input logic redir,
                                input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.ready = ready; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are set #1 after an edge; outputs are sampled #1 after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
        imem_ack       = ack;
        imem_rdata     = ack ? mem_word(imem_addr) : $urandom;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        prev_req, prev_ack, prev_valid, prev_ready, prev_redir, expect_empty;
        logic [31:0] prev_addr, prev_pc;
        int          pops;

        //          ack ready redir rpc            req addr          valid pc
        vecs[0]  = mk(1, 1, 0, 32'h0,          1, 32'h0,   0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 32'h0,          1, 32'h4,   1, 32'h0);
        vecs[2]  = mk(1, 1, 0, 32'h0,          1, 32'h8,   1, 32'h4);
        vecs[3]  = mk(1, 1, 0, 32'h0,          1, 32'hC,   1, 32'h8);
        vecs[4]  = mk(0, 1, 0, 32'h0,          1, 32'hC,   0, 32'h0);
        vecs[5]  = mk(1, 0, 0, 32'h0,          1, 32'h10,  1, 32'hC);
        vecs[6]  = mk(1, 0, 0, 32'h0,          1, 32'h14,  1, 32'hC);
        vecs[7]  = mk(1, 0, 0, 32'h0,          1, 32'h18,  1, 32'hC);
        vecs[8]  = mk(1, 0, 0, 32'h0,          0, 32'h0,   1, 32'hC);
        vecs[9]  = mk(1, 0, 0, 32'h0,          0, 32'h0,   1, 32'hC);
        vecs[10] = mk(0, 1, 0, 32'h0,          1, 32'h1C,  1, 32'h10);
        vecs[11] = mk(0, 1, 0, 32'h0,          1, 32'h1C,  1, 32'h14);
        vecs[12] = mk(0, 1, 0, 32'h0,          1, 32'h1C,  1, 32'h18);
        vecs[13] = mk(0, 1, 0, 32'h0,          1, 32'h1C,  0, 32'h0);
        vecs[14] = mk(0, 1, 1, 32'h103,        1, 32'h1C,  0, 32'h0);
        vecs[15] = mk(0, 1, 0, 32'h0,          1, 32'h1C,  0, 32'h0);
        vecs[16] = mk(0, 1, 0, 32'h0,          1, 32'h1C,  0, 32'h0);
        vecs[17] = mk(1, 1, 0, 32'h0,          0, 32'h0,   0, 32'h0);
        vecs[18] = mk(0, 1, 0, 32'h0,          1, 32'h100, 0, 32'h0);
        vecs[19] = mk(1, 0, 0, 32'h0,          1, 32'h104, 1, 32'h100);
        vecs[20] = mk(1, 1, 1, 32'h200,        0, 32'h0,   0, 32'h0);
        vecs[21] = mk(0, 0, 0, 32'h0,          1, 32'h200, 0, 32'h0);
        vecs[22] = mk(1, 1, 0, 32'h0,          1, 32'h204, 1, 32'h200);
        vecs[23] = mk(0, 1, 0, 32'h0,          1, 32'h204, 0, 32'h0);
        vecs[24] = mk(0, 1, 1, 32'h300,        1, 32'h204, 0, 32'h0);
        vecs[25] = mk(0, 1, 1, 32'h400,        1, 32'h204, 0, 32'h0);
        vecs[26] = mk(1, 1, 0, 32'h0,          0, 32'h0,   0, 32'h0);
        vecs[27] = mk(0, 1, 0, 32'h0,          1, 32'h400, 0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset req", imem_req, 1'b0);
        check("reset addr", imem_addr, 32'h0);
        check("reset valid", inst_valid, 1'b0);
        check("reset data", inst_data, 32'h0);
        check("reset pc", inst_pc, 32'h0);
`ifdef FETCH_STATS_EN
        check("reset stall", stall_cycles, 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            step();
            check($sformatf("vec%0d req", i), imem_req, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d valid", i), inst_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d pc", i), inst_pc, vecs[i].e_pc);
                check($sformatf("vec%0d data", i), inst_data, mem_word(vecs[i].e_pc));
            end
        end

        // Asynchronous reset in the middle of an outstanding request
        drive(1, 0, 0, 32'h0);
        step();
        check("pre-rst valid", inst_valid, 1'b1);
        check("pre-rst pc", inst_pc, 32'h400);
        check("pre-rst req", imem_req, 1'b1);
        drive(0, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst req", imem_req, 1'b0);
        check("async rst valid", inst_valid, 1'b0);
        check("async rst pc", inst_pc, 32'h0);
        step();
        rst_n = 1'b1;
        drive(0, 1, 0, 32'h0);
        step();
        check("post-rst req", imem_req, 1'b1);
        check("post-rst addr", imem_addr, 32'h0);

`ifdef FETCH_STATS_EN
        begin
            logic [31:0] s0, s1;
            s0 = stall_cycles;
            for (int i = 0; i < 10; i++) begin
                drive(0, 1, 0, 32'h0);
                step();
            end
            check("stall ge 10", (stall_cycles >= 32'd10), 1'b1);
            check("stall delta", stall_cycles, s0 + 32'd10);
            drive(1, 0, 0, 32'h0);
            step();
            s1 = stall_cycles;
            for (int i = 0; i < 3; i++) begin
                drive(0, 0, 0, 32'h0);
                step();
            end
            check("stall held valid", stall_cycles, s1);
        end
`endif

        // Random traffic against a stream model: delivered PCs run sequentially from the last redirect.
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0);
        step();
        rst_n = 1'b1;
        exp_pc = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        prev_redir = 1'b0; expect_empty = 1'b0; prev_addr = '0; prev_pc = '0;
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        ack, ready, redir;
            logic [31:0] rpc;
            if (prev_req && !prev_ack) begin
                check("rnd req held", imem_req, 1'b1);
                check("rnd addr held", imem_addr, prev_addr);
            end
            if (prev_valid && !prev_ready && !prev_redir) begin
                check("rnd head held", inst_valid, 1'b1);
                check("rnd head pc", inst_pc, prev_pc);
            end
            if (expect_empty) check("rnd flush empty", inst_valid, 1'b0);
            ack   = imem_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : $urandom;
            if (inst_valid && ready) begin
                check("rnd pop pc", inst_pc, exp_pc);
                check("rnd pop data", inst_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
            expect_empty = redir;
            prev_req = imem_req; prev_ack = ack; prev_addr = imem_addr;
            prev_valid = inst_valid; prev_ready = ready; prev_redir = redir; prev_pc = inst_pc;
            drive(ack, ready, redir, rpc);
            step();
        end
        check("rnd progress", (pops > 500), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
